// File: rtl/pwd_matcher.sv
// Password matcher: scans the lock's password register file one slot per two cycles,
// drives unlock on a match, counts failed attempts and enforces a timed lockout.
// Optional master override code is compiled in when MASTER_CODE_EN is defined.
//
// Handshake: check is a single-cycle request, accepted only while busy==0;
// requests seen while busy==1 are dropped, never queued.
module pwd_matcher #(
    parameter int NUM_SLOTS      = 4,
    parameter int ADDR_W         = 2,
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 100,
    parameter int LOCKOUT_CYCLES = 1000
`ifdef MASTER_CODE_EN
    ,
    parameter logic [15:0] MASTER_CODE = 16'hA5A5
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       code_in,
    input  logic              check,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [16:0]       rf_data,
    output logic              busy,
    output logic              unlock,
    output logic              fail,
    output logic              locked_out,
    output logic [1:0]        fail_count,
    output logic [2:0]        state_dbg
);

    localparam int DWELL_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = $clog2(DWELL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET     = 3'd1,
        S_CMP     = 3'd2,
        S_UNLOCK  = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t               state;
    logic [15:0]          code_latched;
    logic [TIMER_W-1:0]   timer;
    logic [1:0]           next_fails;
    logic                 slot_hit;
    logic                 last_slot;

    always_comb begin
        next_fails = (fail_count == 2'(MAX_FAILS)) ? fail_count : fail_count + 2'd1;
        slot_hit   = rf_data[16] && (rf_data[15:0] == code_latched);
        last_slot  = (read_addr == ADDR_W'(NUM_SLOTS - 1));
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // read_addr doubles as the scan index, so it keeps its last slot outside a scan.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            read_addr    <= '0;
            unlock       <= 1'b0;
            fail         <= 1'b0;
            locked_out   <= 1'b0;
            fail_count   <= 2'd0;
            code_latched <= 16'd0;
            timer        <= '0;
        end else begin
            fail <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (check) begin
                        code_latched <= code_in;
                        read_addr    <= '0;
                        state        <= S_SET;
`ifdef MASTER_CODE_EN
                        if (code_in == MASTER_CODE) begin
                            state      <= S_UNLOCK;
                            unlock     <= 1'b1;
                            fail_count <= 2'd0;
                            timer      <= TIMER_W'(UNLOCK_CYCLES - 1);
                        end
`endif
                    end
                end
                S_SET: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (slot_hit) begin
                        state      <= S_UNLOCK;
                        unlock     <= 1'b1;
                        fail_count <= 2'd0;
                        timer      <= TIMER_W'(UNLOCK_CYCLES - 1);
                    end else if (last_slot) begin
                        state <= S_FAIL;
                    end else begin
                        read_addr <= read_addr + ADDR_W'(1);
                        state     <= S_SET;
                    end
                end
                S_UNLOCK: begin
                    if (timer == '0) begin
                        unlock <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                // The fail pulse and the new count appear together as this state is left.
                S_FAIL: begin
                    fail       <= 1'b1;
                    fail_count <= next_fails;
                    if (next_fails == 2'(MAX_FAILS)) begin
                        state      <= S_LOCKOUT;
                        locked_out <= 1'b1;
                        timer      <= TIMER_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        locked_out <= 1'b0;
                        fail_count <= 2'd0;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
`ifdef MASTER_CODE_EN
                    if (check && (code_in == MASTER_CODE)) begin
                        code_latched <= code_in;
                        locked_out   <= 1'b0;
                        fail_count   <= 2'd0;
                        unlock       <= 1'b1;
                        timer        <= TIMER_W'(UNLOCK_CYCLES - 1);
                        state        <= S_UNLOCK;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwd_matcher.sv
// Directed bench for pwd_matcher with a small register-file model on the read port.
// Cycle k after an accepted check is observed on the falling edge inside cycle T+k.
module tb_pwd_matcher;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] code_in = 16'd0;
    logic        check = 1'b0;
    logic [1:0]  read_addr;
    logic [16:0] rf_data;
    logic        busy, unlock, fail, locked_out;
    logic [1:0]  fail_count;
    logic [2:0]  state_dbg;

    logic [16:0] rf [4];
    logic [1:0]  exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign rf_data = rf[read_addr];

    pwd_matcher #(
        .NUM_SLOTS(4),
        .ADDR_W(2),
        .MAX_FAILS(3),
        .UNLOCK_CYCLES(4),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .code_in(code_in),
        .check(check),
        .read_addr(read_addr),
        .rf_data(rf_data),
        .busy(busy),
        .unlock(unlock),
        .fail(fail),
        .locked_out(locked_out),
        .fail_count(fail_count),
        .state_dbg(state_dbg)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Pulses check for one edge (edge T) and returns just after that edge.
    task automatic issue_check(input logic [15:0] code);
        @(negedge clk);
        check   = 1'b1;
        code_in = code;
        @(posedge clk);
        #1;
        check   = 1'b0;
        code_in = 16'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic fill_invalid(input logic [15:0] data);
        for (int i = 0; i < 4; i++) rf[i] = {1'b0, data};
    endtask

    // A full failing scan, checking the fail pulse and the resulting count.
    task automatic failing_attempt(input logic [15:0] code, input logic [1:0] exp_count, input string name);
        issue_check(code);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s fail k=%0d", name, k), fail, (k == 10));
            check_eq($sformatf("%s unlock k=%0d", name, k), unlock, 1'b0);
        end
        check_eq($sformatf("%s fail_count", name), fail_count, exp_count);
    endtask

    initial begin
        fill_invalid(16'h0000);
        do_reset();
        @(negedge clk);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset unlock", unlock, 1'b0);
        check_eq("reset fail", fail, 1'b0);
        check_eq("reset locked_out", locked_out, 1'b0);
        check_eq("reset fail_count", fail_count, 2'd0);
        check_eq("reset read_addr", read_addr, 2'd0);

        // Match in slot 1: scan stops there, unlock for T+5..T+8.
        fill_invalid(16'h0000);
        rf[1] = {1'b1, 16'hFFFF};
        issue_check(16'hFFFF);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("match read_addr k=%0d", k), read_addr, (k <= 2) ? 2'd0 : 2'd1);
            check_eq($sformatf("match unlock k=%0d", k), unlock, (k >= 5 && k <= 8));
            check_eq($sformatf("match busy k=%0d", k), busy, (k <= 8));
            check_eq($sformatf("match fail k=%0d", k), fail, 1'b0);
        end
        check_eq("match fail_count", fail_count, 2'd0);

        // All slots invalid but carrying the entered code: still a miss everywhere.
        fill_invalid(16'h1234);
        exp_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        issue_check(16'h1234);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 8) check_eq($sformatf("scan read_addr k=%0d", k), read_addr, exp_q.pop_front());
            check_eq($sformatf("scan fail k=%0d", k), fail, (k == 10));
            check_eq($sformatf("scan busy k=%0d", k), busy, (k <= 9));
            check_eq($sformatf("scan unlock k=%0d", k), unlock, 1'b0);
            if (k == 10) check_eq("scan fail_count", fail_count, 2'd1);
        end
        check_eq("scan locked_out", locked_out, 1'b0);

        // Data matches in slot 2 but its valid bit is clear.
        fill_invalid(16'h0000);
        rf[2] = {1'b0, 16'hBEEF};
        failing_attempt(16'hBEEF, 2'd2, "invalid_slot");

        // Third failure enters lockout; a master-code check arrives at k=12.
        issue_check(16'h7777);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_eq($sformatf("lock fail k=%0d", k), fail, (k == 10));
            if (k >= 7) check_eq($sformatf("lock read_addr k=%0d", k), read_addr, 2'd3);
`ifdef MASTER_CODE_EN
            check_eq($sformatf("lock locked_out k=%0d", k), locked_out, (k >= 10 && k <= 12));
            check_eq($sformatf("lock unlock k=%0d", k), unlock, (k >= 13 && k <= 16));
            check_eq($sformatf("lock busy k=%0d", k), busy, (k <= 16));
            check_eq($sformatf("lock fail_count k=%0d", k), fail_count,
                     (k < 10) ? 2'd2 : (k <= 12) ? 2'd3 : 2'd0);
`else
            check_eq($sformatf("lock locked_out k=%0d", k), locked_out, (k >= 10 && k <= 17));
            check_eq($sformatf("lock unlock k=%0d", k), unlock, 1'b0);
            check_eq($sformatf("lock busy k=%0d", k), busy, (k <= 17));
            check_eq($sformatf("lock fail_count k=%0d", k), fail_count,
                     (k < 10) ? 2'd2 : (k <= 17) ? 2'd3 : 2'd0);
`endif
            if (k == 12) begin
                check   = 1'b1;
                code_in = 16'hA5A5;
            end else if (k == 13) begin
                check   = 1'b0;
            end
        end

        // Reset mid-scan clears a nonzero fail count and the scan position.
        fill_invalid(16'h0000);
        failing_attempt(16'h4321, 2'd1, "pre_reset");
        rf[1] = {1'b1, 16'hFFFF};
        issue_check(16'hFFFF);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        check_eq("pre-reset read_addr", read_addr, 2'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("midscan busy", busy, 1'b0);
        check_eq("midscan unlock", unlock, 1'b0);
        check_eq("midscan fail", fail, 1'b0);
        check_eq("midscan locked_out", locked_out, 1'b0);
        check_eq("midscan fail_count", fail_count, 2'd0);
        check_eq("midscan read_addr", read_addr, 2'd0);
        @(negedge clk);
        check_eq("post-reset no unlock", unlock, 1'b0);
        check_eq("post-reset idle", busy, 1'b0);

        // Fresh check after reset behaves normally.
        issue_check(16'hFFFF);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq($sformatf("fresh unlock k=%0d", k), unlock, (k >= 5 && k <= 8));
            check_eq($sformatf("fresh busy k=%0d", k), busy, (k <= 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwd_matcher.md
Name: pwd_matcher

Overview:
- Read-side consumer of the lock's password register file: 4 slots, each 17 bits (bit 16 = valid, bits 15:0 = password).
- On a `check` request, latches the entered 16-bit code and scans the slots through the file's read port, one slot at a time.
- Drives the unlock output on a match.
- Counts consecutive failed attempts and enforces a timed lockout.
- Sits between the keypad entry logic and the door actuator.

Parameters:
- NUM_SLOTS, 4: number of register-file slots scanned, indices 0..NUM_SLOTS-1.
- ADDR_W, 2: width of read_addr; must satisfy 2^ADDR_W >= NUM_SLOTS.
- MAX_FAILS, 3: consecutive failures that trigger lockout.
- UNLOCK_CYCLES, 100: clock cycles `unlock` stays high after a match.
- LOCKOUT_CYCLES, 1000: clock cycles `locked_out` stays high.
- MASTER_CODE, 16'hA5A5: override code, used only when MASTER_CODE_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- code_in  in  16  entered code; sampled only on an accepted check.
- check  in  1  single-cycle request to verify code_in.
- read_addr  out  ADDR_W  slot index driven to the register-file read port.
- rf_data  in  17  register-file read data for read_addr; combinational, settles within one cycle.
- busy  out  1  high in every state except IDLE.
- unlock  out  1  held high for UNLOCK_CYCLES after a match.
- fail  out  1  one-cycle pulse when the attempt fails.
- locked_out  out  1  high while in lockout.
- fail_count  out  2  current consecutive-failure count.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; read_addr=0, busy=0, unlock=0, fail=0, locked_out=0, fail_count=0; latched code cleared. Reset overrides any in-progress scan, unlock or lockout.
- States:
  - IDLE
  - SET: read_addr=idx, data settling.
  - CMP: sample rf_data.
  - UNLOCK
  - FAIL: one cycle.
  - LOCKOUT
- IDLE: check==1 at edge T latches code_in and sets idx=0; state=SET at T+1. check is ignored in every other state; there is no queuing.
- Slot i: SET at T+1+2i, CMP at T+2+2i.
- Match condition in CMP: rf_data[16]==1 and rf_data[15:0]==latched code. A slot with the valid bit clear is a miss, even if its data field matches.
- Match: state=UNLOCK; unlock=1 from T+3+2i for exactly UNLOCK_CYCLES cycles; fail_count cleared to 0 in the same cycle; then IDLE. The scan stops early, so higher slots are not read.
- Miss with idx<NUM_SLOTS-1: idx+1, back to SET.
- Miss on last slot: state=FAIL, so fail=1 at T+2+2*NUM_SLOTS (T+10 for 4 slots); fail_count increments (saturates at MAX_FAILS).
  - If the new count equals MAX_FAILS: next state LOCKOUT.
  - Otherwise: next state IDLE.
- LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles; at exit fail_count=0, state=IDLE.
- read_addr holds its last value outside SET/CMP. It returns to 0 only on reset or on a newly accepted check.
- Dwell timers: a single down-counter, width clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1), loaded on state entry.
- Register-file writes during a scan are not blocked. Each slot's comparison uses whatever rf_data holds in that slot's CMP cycle.

Optional Feature:
- Macro: MASTER_CODE_EN.
- Defined:
  - A check whose code_in==MASTER_CODE goes directly to UNLOCK at T+1, skipping the scan.
  - The master code is also accepted while in LOCKOUT. In that case lockout aborts, fail_count=0, and UNLOCK is entered next cycle.
- Undefined: no master comparator exists; MASTER_CODE has no effect; a check during LOCKOUT is ignored.

Test Plan:
- Slot 1 = {1,16'hFFFF}, other slots invalid; UNLOCK_CYCLES=4. check with code_in=16'hFFFF at T -> read_addr 0 then 1; unlock=1 during T+5..T+8; fail never asserts; busy low again at T+9.
- All slots invalid. check with 16'h1234 -> fail pulses exactly at T+10; fail_count=1; unlock stays 0.
- MAX_FAILS=3, LOCKOUT_CYCLES=8. Three failing checks -> locked_out=1 for 8 cycles; a check during that window is ignored; afterwards fail_count=0.
- Slot 2 = {0,16'hBEEF}. check with 16'hBEEF -> fail, since the valid bit is clear.
- Reset driven low during the scan at T+4 -> next edge: IDLE, all outputs 0. A fresh check then proceeds normally.
- With MASTER_CODE_EN: during LOCKOUT, check with 16'hA5A5 -> locked_out=0 and unlock=1 on the following cycle; without the macro, the same check is ignored.
